// File: rtl/pc_fetch_stage.sv
// Instruction fetch stage: owns the word-addressed PC and the IF/ID register.
// It redirects on branch_taken and latches a sticky error if memory never answers.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] new_PC,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        if_flush,
    output logic        fetch_error,
    output logic [1:0]  state_dbg
);

    // Handshake: a fetch completes in the cycle where imem_req && imem_ready;
    // imem_rdata is captured on that same rising edge. No other cycle moves data.

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state, state_next;
    logic [31:0] pc;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_cnt_plus;
    logic        redirect;
    logic        transfer;
    logic        cnt_inc;
    logic        hit_timeout;

    assign imem_addr     = pc;
    assign state_dbg     = state;
    assign wait_cnt_plus = wait_cnt + 8'd1;

    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        redirect    = 1'b0;
        transfer    = 1'b0;
        cnt_inc     = 1'b0;
        hit_timeout = 1'b0;
        case (state)
            ST_BOOT: begin
                state_next = ST_FETCH;
                redirect   = branch_taken;
            end
            ST_FETCH: begin
                imem_req = !stall && !branch_taken;
                redirect = branch_taken;
                transfer = imem_req && imem_ready;
                if (imem_req && !imem_ready) begin
                    cnt_inc = 1'b1;
                    if (wait_cnt_plus == TIMEOUT_CNT) begin
                        hit_timeout = 1'b1;
                        state_next  = ST_ERROR;
                    end
                end
            end
            ST_ERROR: begin
                state_next = ST_ERROR;
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_BOOT;
            pc          <= RESET_PC;
            wait_cnt    <= 8'd0;
            if_id_pc    <= 32'd0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            if_flush    <= 1'b0;
            fetch_error <= 1'b0;
        end else begin
            state    <= state_next;
            if_flush <= redirect;
            if (redirect) begin
                // A redirect wins over stall and discards any same-cycle fetch.
                pc          <= new_PC;
                if_id_pc    <= 32'd0;
                if_id_instr <= NOP_INSTR;
                if_id_valid <= 1'b0;
                wait_cnt    <= 8'd0;
            end else if (transfer) begin
                pc          <= pc + 32'd1;
                if_id_pc    <= pc;
                if_id_instr <= imem_rdata;
                if_id_valid <= 1'b1;
                wait_cnt    <= 8'd0;
            end else if (cnt_inc) begin
                if_id_instr <= NOP_INSTR;
                if_id_valid <= 1'b0;
                wait_cnt    <= wait_cnt_plus;
                if (hit_timeout) begin
                    fetch_error <= 1'b1;
                end
            end else if (state == ST_ERROR) begin
                if_id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: expected IF/ID loads are queued by the
// stimulus and consumed by an independent monitor; cycle-level checks sit inline.
module tb_pc_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] new_PC;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        if_flush;
    logic        fetch_error;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    pc_fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .new_PC       (new_PC),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid),
        .if_flush     (if_flush),
        .fetch_error  (fetch_error),
        .state_dbg    (state_dbg)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {16'hA000, a[15:0]};
    endfunction

    // Instruction memory: answers combinationally from the requested address.
    assign imem_rdata = instr_of(imem_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back({pc, instr_of(pc)});
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   64'(imem_req),    64'd0);
        check({tag, "_addr"},  64'(imem_addr),   64'd0);
        check({tag, "_pc"},    64'(if_id_pc),    64'd0);
        check({tag, "_instr"}, 64'(if_id_instr), 64'(NOP));
        check({tag, "_valid"}, 64'(if_id_valid), 64'd0);
        check({tag, "_flush"}, 64'(if_flush),    64'd0);
        check({tag, "_err"},   64'(fetch_error), 64'd0);
        check({tag, "_state"}, 64'(state_dbg),   64'd0);
    endtask

    // Monitor: each newly presented valid IF/ID entry must match the queue head.
    logic        prev_valid = 1'b0;
    logic [31:0] prev_pc    = 32'd0;
    logic [31:0] prev_instr = 32'd0;

    always @(negedge clk) begin
        if (reset && if_id_valid &&
            (!prev_valid || if_id_pc != prev_pc || if_id_instr != prev_instr)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ifid: got pc %0h instr %0h with nothing expected",
                         if_id_pc, if_id_instr);
            end else begin
                check("ifid_entry", {if_id_pc, if_id_instr}, exp_q.pop_front());
            end
        end
        prev_valid = if_id_valid;
        prev_pc    = if_id_pc;
        prev_instr = if_id_instr;
    end

    // Directed stimulus
    initial begin
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        new_PC = 32'd0; imem_ready = 1'b0;
        step(); step();
        check_reset_outputs("rst");

        // Sequential fetch from reset
        reset = 1'b1; imem_ready = 1'b1;
        #1 check("boot_req", 64'(imem_req), 64'd0);
        for (int i = 0; i < 5; i++) push_exp(32'(i));
        step();
        check("first_req", 64'(imem_req), 64'd1);
        check("first_addr", 64'(imem_addr), 64'd0);
        for (int i = 1; i <= 5; i++) begin
            step();
            check("seq_addr", 64'(imem_addr), 64'(i));
        end

        // Stall for three cycles at PC=5
        stall = 1'b1;
        #1 check("stall_req", 64'(imem_req), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr",  64'(imem_addr),   64'd5);
            check("stall_req_h", 64'(imem_req),    64'd0);
            check("stall_pc",    64'(if_id_pc),    64'd4);
            check("stall_instr", 64'(if_id_instr), 64'(instr_of(32'd4)));
            check("stall_valid", 64'(if_id_valid), 64'd1);
        end
        stall = 1'b0;
        push_exp(32'd5); push_exp(32'd6);
        #1 check("resume_req", 64'(imem_req), 64'd1);
        step(); check("resume_addr6", 64'(imem_addr), 64'd6);
        step(); check("resume_addr7", 64'(imem_addr), 64'd7);

        // Branch with coincident stall and ready at PC=7
        branch_taken = 1'b1; new_PC = 32'h40; stall = 1'b1;
        #1 check("br_req", 64'(imem_req), 64'd0);
        step();
        check("br_addr",  64'(imem_addr),   64'h40);
        check("br_valid", 64'(if_id_valid), 64'd0);
        check("br_instr", 64'(if_id_instr), 64'(NOP));
        check("br_pc",    64'(if_id_pc),    64'd0);
        check("br_flush", 64'(if_flush),    64'd1);
        branch_taken = 1'b0; stall = 1'b0; imem_ready = 1'b0; new_PC = 32'h99;
        step();
        check("flush_pulse", 64'(if_flush),    64'd0);
        check("nop_addr",    64'(imem_addr),   64'h40);
        check("nop_valid",   64'(if_id_valid), 64'd0);
        check("nop_instr",   64'(if_id_instr), 64'(NOP));
        imem_ready = 1'b1; push_exp(32'h40);
        step();
        check("post_br_addr", 64'(imem_addr), 64'h41);

        // PC wrap at 0xFFFFFFFF
        branch_taken = 1'b1; new_PC = 32'hFFFF_FFFF; imem_ready = 1'b0;
        step();
        check("wrap_target", 64'(imem_addr), 64'hFFFF_FFFF);
        check("wrap_flush",  64'(if_flush),  64'd1);
        branch_taken = 1'b0; imem_ready = 1'b1; push_exp(32'hFFFF_FFFF);
        step();
        check("wrap_addr", 64'(imem_addr), 64'd0);
        check("wrap_pc",   64'(if_id_pc),  64'hFFFF_FFFF);

        // Memory timeout
        imem_ready = 1'b0; new_PC = 32'h1234;
        repeat (14) step();
        check("pre_to_err", 64'(fetch_error), 64'd0);
        check("pre_to_req", 64'(imem_req),    64'd1);
        step();
        check("to_err",   64'(fetch_error), 64'd1);
        check("to_req",   64'(imem_req),    64'd0);
        check("to_state", 64'(state_dbg),   64'd2);
        check("to_valid", 64'(if_id_valid), 64'd0);
        branch_taken = 1'b1; new_PC = 32'h80; stall = 1'b1;
        step();
        check("err_addr",  64'(imem_addr),   64'd0);
        check("err_flush", 64'(if_flush),    64'd0);
        check("err_stick", 64'(fetch_error), 64'd1);
        check("err_req",   64'(imem_req),    64'd0);
        branch_taken = 1'b0; stall = 1'b0;
        #3 reset = 1'b0;
        #1 check_reset_outputs("err_rst");

        // Restart, then asynchronous reset between edges mid-fetch
        step();
        reset = 1'b1; imem_ready = 1'b1;
        #1 check("reboot_req", 64'(imem_req), 64'd0);
        push_exp(32'd0); push_exp(32'd1);
        step();
        check("reboot_req1", 64'(imem_req),  64'd1);
        check("reboot_addr", 64'(imem_addr), 64'd0);
        step(); check("reboot_addr1", 64'(imem_addr), 64'd1);
        step(); check("reboot_addr2", 64'(imem_addr), 64'd2);
        imem_ready = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_reset_outputs("async_rst");
        step();
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
